// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Glyphs are active-low, bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = 7'h40;
      4'd1: seg_o = 7'h79;
      4'd2: seg_o = 7'h24;
      4'd3: seg_o = 7'h30;
      4'd4: seg_o = 7'h19;
      4'd5: seg_o = 7'h12;
      4'd6: seg_o = 7'h02;
      4'd7: seg_o = 7'h78;
      4'd8: seg_o = 7'h00;
      4'd9: seg_o = 7'h10;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with blanking gap,
// leading-zero suppression and frame-synchronous double-buffered data.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZS          = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       en_in,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic                        frame_start
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = BCD_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] shd_en_q, shd_en_d;
  logic                  pending_q, pending_d;
  logic [DATA_W-1:0]     act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;

  scan_state_e           state_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  frame_start_q;

  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] zero_above;
  logic [NUM_DIGITS-1:0] dig_blank;
  logic                  all_zero;
  logic [BCD_W-1:0]      cur_bcd;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the wrap clock still leaves pending set: the old shadow moves
  // to active on that same edge while the new data lands in the shadow.
  always_comb begin
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    shd_en_d   = shd_en_q;
    pending_d  = pending_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    if (frame_end && pending_q) begin
      act_data_d = shd_data_q;
      act_dp_d   = shd_dp_q;
      act_en_d   = shd_en_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shd_data_d = data_in;
      shd_dp_d   = dp_in;
      shd_en_d   = en_in;
      pending_d  = 1'b1;
    end
  end

  // zero_above[i]: every enabled digit from i up to the most significant is 0.
  always_comb begin
    all_zero   = 1'b1;
    zero_above = '0;
    dig_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (act_en_q[i] && (act_data_q[BCD_W*i +: BCD_W] != '0)) begin
        all_zero = 1'b0;
      end
      zero_above[i] = all_zero;
      dig_blank[i]  = !act_en_q[i] || ((LZS != 0) && (i != 0) && zero_above[i]);
    end
  end

  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_bcd   = act_data_q[BCD_W*i +: BCD_W];
        cur_dp    = act_dp_q[i];
        cur_blank = dig_blank[i];
      end
    end
  end

  bcd_seg_decode u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      shd_en_q   <= '0;
      pending_q  <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      shd_en_q   <= shd_en_d;
      pending_q  <= pending_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
    end
  end

  // state_q tracks cnt_q; pins are registered from state_q, one clock behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_end;
      case (state_q)
        BLANK: begin
          an_q  <= '1;
          seg_q <= SEG_BLANK;
          dp_q  <= 1'b1;
          if (cnt_d == CNT_BLANK) begin
            state_q <= SHOW;
          end
        end
        SHOW: begin
          an_q  <= ~(NUM_DIGITS'(1) << idx_q);
          seg_q <= cur_blank ? SEG_BLANK : dec_seg;
          dp_q  <= cur_blank ? 1'b1 : ~cur_dp;
          if (slot_end) begin
            state_q <= BLANK;
          end
        end
        default: begin
          state_q <= BLANK;
          an_q    <= '1;
          seg_q   <= SEG_BLANK;
          dp_q    <= 1'b1;
        end
      endcase
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 8-clock slots, 2-clock blanking.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .BLANK_CYCLES (2),
    .LZS          (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .en_in       (en_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge where frame_start is high; n = negedges taken.
  task automatic wait_frame(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    chk({tag, "_seen"}, 32'(frame_start), 32'd1);
  endtask

  // Called at a frame_start negedge; checks one whole frame, optionally
  // driving up to two loads at given offsets (-1 = none).
  task automatic check_frame(input string name,
                             input logic [27:0] eseg, input logic [3:0] edp,
                             input int oa, input logic [15:0] da,
                             input logic [3:0] ena, input logic [3:0] dpa,
                             input int ob, input logic [15:0] db,
                             input logic [3:0] enb, input logic [3:0] dpb);
    logic [3:0] one;
    int slot, pos;
    one = 4'b0001;
    for (int off = 0; off < 32; off++) begin
      if (off == oa) begin
        load = 1'b1; data_in = da; en_in = ena; dp_in = dpa;
      end else if (off == ob) begin
        load = 1'b1; data_in = db; en_in = enb; dp_in = dpb;
      end
      @(negedge clk);
      load = 1'b0;
      slot = off / 8;
      pos  = off % 8;
      if (pos == 0) begin
        chk($sformatf("%s_d%0d_blank_an", name, slot), 32'(an), 32'hF);
        chk($sformatf("%s_d%0d_blank_seg", name, slot), 32'(seg), 32'h7F);
      end
      if (pos == 3) begin
        chk($sformatf("%s_d%0d_an", name, slot), 32'(an), 32'(4'hF & ~(one << slot)));
        chk($sformatf("%s_d%0d_seg", name, slot), 32'(seg), 32'(eseg[7*slot +: 7]));
        chk($sformatf("%s_d%0d_dp", name, slot), 32'(dp), 32'(edp[slot]));
        chk($sformatf("%s_d%0d_fs", name, slot), 32'(frame_start), 32'd0);
      end
    end
    chk({name, "_frame_start"}, 32'(frame_start), 32'd1);
  endtask

  int n;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1;

    wait_frame("first_frame", n);
    chk("first_frame_latency", 32'(n), 32'd32);
    wait_frame("period", n);
    chk("frame_period", 32'(n), 32'd32);

    // Blank frame while 1234 is loaded; it appears from the following frame.
    check_frame("idle", {4{7'h7F}}, 4'hF,
                0, 16'h1234, 4'hF, 4'b0100, -1, '0, '0, '0);
    check_frame("f1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011,
                0, 16'h0070, 4'hF, 4'b0000, -1, '0, '0, '0);
    check_frame("lzs", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF,
                0, 16'hAF09, 4'b1101, 4'b0000, -1, '0, '0, '0);
    // Load 5678 early, then 9999 on the wrap clock itself.
    check_frame("inval", {7'h3F, 7'h3F, 7'h7F, 7'h10}, 4'hF,
                4, 16'h5678, 4'hF, 4'b0001, 31, 16'h9999, 4'b0011, 4'b0000);
    check_frame("wrap_old", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1110,
                -1, '0, '0, '0, -1, '0, '0, '0);
    check_frame("wrap_new", {7'h7F, 7'h7F, 7'h10, 7'h10}, 4'hF,
                3, 16'h0001, 4'hF, 4'b0000, 20, 16'h2580, 4'hF, 4'b1000);
    check_frame("last_wins", {7'h24, 7'h12, 7'h00, 7'h40}, 4'b0111,
                -1, '0, '0, '0, -1, '0, '0, '0);

    // Leave a load pending, then reset in the middle of digit 0's SHOW phase.
    load = 1'b1; data_in = 16'h1111; en_in = 4'hF; dp_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'hE);
    chk("pre_rst_seg", 32'(seg), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame("post_rst", n);
    chk("post_rst_latency", 32'(n), 32'd32);
    check_frame("post_rst", {4{7'h7F}}, 4'hF,
                -1, '0, '0, '0, -1, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds a frame of BCD digits, steps one anode at a time, and drives one shared BCD-to-segment decoder for the active digit.
- Inserts a blanking gap between digits to stop ghosting, and updates displayed data only at frame boundaries so digits never tear.
- Sits between the datapath (counters, register-file probes) and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- CLK_DIV, 100000, clocks per digit slot (must be > BLANK_CYCLES+1).
- BLANK_CYCLES, 1000, clocks at start of each slot with all anodes off.
- LZS, 1, leading-zero suppression enable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture strobe for data_in/dp_in/en_in.
- data_in  in  4*NUM_DIGITS  BCD digits; digit i = data_in[4i+3:4i], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- en_in  in  NUM_DIGITS  digit enable mask, 0 = digit always blank.
- an  out  NUM_DIGITS  anode selects, active-low.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-clock pulse when digit index wraps to 0.

Behaviour:
- Reset (async assert, sync release on clk):
  - an = all 1s, seg = 7'h7F, dp = 1, frame_start = 0.
  - Shadow and active registers = 0; pending = 0.
  - Slot counter = 0, digit index = 0, state = BLANK.
- Slot counter runs 0..CLK_DIV-1 and wraps. At wrap, index increments modulo NUM_DIGITS.
- frame_start = 1 for exactly the clock in which index becomes 0.
- State machine, 2 states:
  - BLANK: counter < BLANK_CYCLES. an = all 1s, seg = 7'h7F, dp = 1.
  - SHOW: counter ≥ BLANK_CYCLES. an[index] = 0, all other anodes = 1. seg and dp come from the active digit.
  - SHOW→BLANK on counter wrap; BLANK→SHOW when counter reaches BLANK_CYCLES.
- Outputs are registered: one clock after the state/counter change.
- Decode of each digit:
  - 0–9 → standard glyphs, e.g. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00.
  - 10–15 → '-' (7'h3F).
- Digit blanking: a digit shows seg = 7'h7F and dp = 1 when either:
  - en[i] = 0, or
  - LZS = 1, i ≠ 0, and every enabled digit j ≥ i holds 0.
- Load path:
  - load = 1 captures data_in, dp_in and en_in into the shadow register and sets pending.
  - At the clock where index wraps to 0 with pending = 1, shadow is copied to active and pending is cleared.
  - The new value is visible from the next frame. Worst-case latency is NUM_DIGITS*CLK_DIV clocks.
- Simultaneous events:
  - load on the same clock as the frame wrap: the old shadow is transferred, the new data is captured, and pending stays 1.
  - Repeated loads within one frame: the last one wins.
- Reset mid-slot immediately blanks the display; any pending data is lost.

Decomposition:
- Shared package (seg_pkg) holds:
  - segment glyph constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F;
  - the BCD_W = 4 constant;
  - the state enum {BLANK, SHOW}.
- Sub-module bcd_seg_decode (combinational, 4-bit in, 7-bit active-low out, dash for 10–15), instantiated once on the muxed digit.
- Leading-zero logic and scan FSM stay in seg_scan_ctrl.

Test Plan (bench: NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, LZS=1):
- Reset held, then released:
  - an = 4'hF and seg = 7'h7F throughout the first 2 clocks of each slot.
  - With active = 0 and en = 0, all outputs stay blank.
  - frame_start pulses every 32 clocks.
- load with data_in = 16'h1234, en_in = 4'hF, dp_in = 4'b0100:
  - No change until the next frame_start.
  - Then an sequence E,D,B,7 in SHOW phases, with seg = 0x19, 0x30, 0x24, 0x79 (digits 4, 3, 2, 1).
  - dp = 0 only while an = 4'hB.
- LZS check: load 16'h0070, en_in = 4'hF:
  - Digits 3 and 2 blank.
  - Digit 1 shows 7'h78 ('7').
  - Digit 0 shows 7'h40 ('0').
- Invalid codes: load 16'hAF09, en_in = 4'b1101:
  - Digit 3 = 7'h3F and digit 2 = 7'h3F.
  - Digit 1 is blank because it is masked.
  - Digit 0 = 7'h10 ('9').
- Simultaneous events:
  - load asserted on the wrap clock: the previous shadow is displayed for this frame and the new value from the following frame.
  - Two loads in one frame: only the second value is displayed.
- Async reset asserted mid-SHOW:
  - an = 4'hF and seg = 7'h7F within the same clock, without waiting for an edge.
  - After release, the index restarts at 0 with the display blank until a new load and frame.
